// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and seed terms for the a(n)=a(n-2)+a(n-3) generator/checker pair
package seq_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  typedef logic [31:0] term_t;

  localparam term_t SEED_A0 = 32'd0;
  localparam term_t SEED_A1 = 32'd1;
  localparam term_t SEED_A2 = 32'd1;

endpackage

// File: rtl/seq_ref_model.sv
// rtl/seq_ref_model.sv - expected-term engine: three term registers and a wrapping adder
module seq_ref_model
  import seq_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  i_load,
  input  logic  i_advance,
  output term_t o_e3
);

  term_t r_e3;
  term_t r_e2;
  term_t r_e1;
  term_t w_sum;

  // Carry is dropped so the sequence wraps exactly like the generator.
  assign w_sum = r_e3 + r_e2;
  assign o_e3  = r_e3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e3 <= SEED_A0;
      r_e2 <= SEED_A1;
      r_e1 <= SEED_A2;
    end else if (i_load) begin
      // The 0 just seen is a(0); queue up a(1), a(2), a(3).
      r_e3 <= SEED_A1;
      r_e2 <= SEED_A2;
      r_e1 <= SEED_A1 + SEED_A0;
    end else if (i_advance) begin
      r_e3 <= r_e2;
      r_e2 <= r_e1;
      r_e1 <= w_sum;
    end
  end

endmodule

// File: rtl/seq_checker.sv
// rtl/seq_checker.sv - lock/track checker for the seq generator; SEQ_CHECKER_ERRCNT_EN builds the error counter
module seq_checker
  import seq_pkg::*;
#(
  parameter int MISS_LIMIT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_i,
  input  logic [31:0]      seq_i,
  output logic             locked_o,
  output logic             match_o,
  output logic             error_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [3:0] MISS_LIM = 4'(MISS_LIMIT);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_miss;
  logic [3:0] w_miss_next;
  logic [3:0] w_miss_inc;
  logic       r_match;
  logic       r_error;
  logic       w_match_nxt;
  logic       w_error_nxt;
  logic       w_load;
  logic       w_advance;
  term_t      w_e3;

  seq_ref_model u_ref (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_load),
    .i_advance (w_advance),
    .o_e3      (w_e3)
  );

  assign w_miss_inc = r_miss + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= HUNT;
      r_miss  <= 4'd0;
      r_match <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_miss  <= w_miss_next;
      r_match <= w_match_nxt;
      r_error <= w_error_nxt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_miss_next  = r_miss;
    w_match_nxt  = 1'b0;
    w_error_nxt  = 1'b0;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    if (valid_i) begin
      case (r_state)
        HUNT: begin
          if (seq_i == SEED_A0) begin
            w_load       = 1'b1;
            w_next_state = TRACK;
          end
        end
        TRACK: begin
          w_advance = 1'b1;
          if (seq_i == w_e3) begin
            w_match_nxt = 1'b1;
            w_miss_next = 4'd0;
          end else begin
            w_error_nxt = 1'b1;
            // Too many misses in a row: drop lock and wait for the next 0.
            if (w_miss_inc == MISS_LIM) begin
              w_next_state = HUNT;
              w_miss_next  = 4'd0;
            end else begin
              w_miss_next = w_miss_inc;
            end
          end
        end
        default: w_next_state = HUNT;
      endcase
    end
  end

  assign locked_o = (r_state == TRACK);
  assign match_o  = r_match;
  assign error_o  = r_error;

`ifdef SEQ_CHECKER_ERRCNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_cnt <= '0;
    end else if (w_error_nxt && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign err_cnt_o = r_err_cnt;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// tb/tb_seq_checker.sv - directed self-checking bench for seq_checker
module tb_seq_checker;

`ifdef SEQ_CHECKER_ERRCNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_i;
  logic [31:0] seq_i;
  logic        locked_o, match_o, error_o;
  logic [15:0] err_cnt_o;

  logic        valid2;
  logic [31:0] seq2;
  logic        locked2, match2, error2;
  logic [1:0]  err_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_checker #(.MISS_LIMIT(3), .CNT_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid_i   (valid_i),
    .seq_i     (seq_i),
    .locked_o  (locked_o),
    .match_o   (match_o),
    .error_o   (error_o),
    .err_cnt_o (err_cnt_o)
  );

  seq_checker #(.MISS_LIMIT(15), .CNT_W(2)) dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid_i   (valid2),
    .seq_i     (seq2),
    .locked_o  (locked2),
    .match_o   (match2),
    .error_o   (error2),
    .err_cnt_o (err_cnt2)
  );

  task automatic drive(input logic v, input logic [31:0] d);
    @(negedge clk);
    valid_i = v;
    seq_i   = d;
    valid2  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic v, input logic [31:0] d);
    @(negedge clk);
    valid2  = v;
    seq2    = d;
    valid_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    valid_i = 1'b0;
    valid2  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    valid_i = 1'b0;
    seq_i   = 32'd0;
    valid2  = 1'b0;
    seq2    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({locked_o, match_o, error_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {locked_o, match_o, error_o});
    end
    checks++;
    if (err_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_errcnt: got %0d expected 0", err_cnt_o);
    end
    checks++;
    if ({locked2, match2, error2, err_cnt2} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_dut2: got %b expected 00000", {locked2, match2, error2, err_cnt2});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_clean();
    int vals[10];
    int nmatch;
    vals   = '{0, 1, 1, 1, 2, 2, 3, 4, 5, 7};
    nmatch = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vals[i]);
      if (match_o === 1'b1) nmatch++;
      checks++;
      if ({locked_o, match_o, error_o} !== {1'b1, (i != 0), 1'b0}) begin
        errors++;
        $display("FAIL clean_step%0d: got lmE=%b expected %b", i, {locked_o, match_o, error_o},
                 {1'b1, (i != 0), 1'b0});
      end
    end
    checks++;
    if (nmatch != 9) begin
      errors++;
      $display("FAIL clean_match_count: got %0d expected 9", nmatch);
    end
    checks++;
    if (err_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL clean_errcnt: got %0d expected 0", err_cnt_o);
    end
  endtask

  task automatic test_single_error();
    int vals[10];
    vals = '{0, 1, 1, 1, 2, 99, 3, 4, 5, 7};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vals[i]);
      checks++;
      if ({locked_o, match_o, error_o} !== {1'b1, (i != 0 && i != 5), (i == 5)}) begin
        errors++;
        $display("FAIL single_err_step%0d: got lmE=%b expected %b", i,
                 {locked_o, match_o, error_o}, {1'b1, (i != 0 && i != 5), (i == 5)});
      end
    end
    checks++;
    if (err_cnt_o !== 16'(CNT_ON)) begin
      errors++;
      $display("FAIL single_err_errcnt: got %0d expected %0d", err_cnt_o, CNT_ON);
    end
  endtask

  task automatic test_loss_of_lock();
    do_reset();
    drive(1'b1, 32'd0);
    drive(1'b1, 32'd1);
    drive(1'b1, 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'd50);
      checks++;
      if ({locked_o, match_o, error_o} !== {(k < 2), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL miss%0d: got lmE=%b expected %b", k, {locked_o, match_o, error_o},
                 {(k < 2), 1'b0, 1'b1});
      end
    end
    drive(1'b1, 32'd5);
    checks++;
    if ({locked_o, match_o, error_o} !== 3'b000) begin
      errors++;
      $display("FAIL hunt_ignore: got lmE=%b expected 000", {locked_o, match_o, error_o});
    end
    drive(1'b1, 32'd0);
    checks++;
    if ({locked_o, match_o, error_o} !== 3'b100) begin
      errors++;
      $display("FAIL relock: got lmE=%b expected 100", {locked_o, match_o, error_o});
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'd1);
      checks++;
      if ({locked_o, match_o, error_o} !== 3'b110) begin
        errors++;
        $display("FAIL relock_match%0d: got lmE=%b expected 110", k, {locked_o, match_o, error_o});
      end
    end
    checks++;
    if (err_cnt_o !== 16'(3 * CNT_ON)) begin
      errors++;
      $display("FAIL loss_errcnt: got %0d expected %0d", err_cnt_o, 3 * CNT_ON);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] terms[200];
    int          idx, nmatch, nerr;
    logic        lk;
    terms[0] = 32'd0;
    terms[1] = 32'd1;
    terms[2] = 32'd1;
    for (int n = 3; n < 200; n++) terms[n] = terms[n-2] + terms[n-3];
    idx = 0;
    nmatch = 0;
    nerr = 0;
    do_reset();
    while (idx < 200) begin
      if ($urandom_range(0, 3) == 0) begin
        lk = locked_o;
        drive(1'b0, $urandom);
        checks++;
        if ({locked_o, match_o, error_o} !== {lk, 2'b00}) begin
          errors++;
          $display("FAIL gap_at%0d: got lmE=%b expected %b", idx, {locked_o, match_o, error_o},
                   {lk, 2'b00});
        end
      end else begin
        drive(1'b1, terms[idx]);
        if (match_o === 1'b1) nmatch++;
        if (error_o === 1'b1) nerr++;
        idx++;
      end
    end
    checks++;
    if (nerr != 0) begin
      errors++;
      $display("FAIL gaps_errors: got %0d expected 0", nerr);
    end
    checks++;
    if (nmatch != 199) begin
      errors++;
      $display("FAIL gaps_matches: got %0d expected 199", nmatch);
    end
    checks++;
    if ({locked_o, err_cnt_o} !== {1'b1, 16'd0}) begin
      errors++;
      $display("FAIL gaps_final: got locked=%b cnt=%0d expected locked=1 cnt=0", locked_o, err_cnt_o);
    end
  endtask

  task automatic test_reset_mid_track();
    do_reset();
    drive(1'b1, 32'd0);
    drive(1'b1, 32'd1);
    drive(1'b1, 32'd1);
    drive(1'b1, 32'd1);
    drive(1'b1, 32'd50);
    valid_i = 1'b0;
    checks++;
    if ({locked_o, error_o} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset: got lE=%b expected 11", {locked_o, error_o});
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({locked_o, match_o, error_o, err_cnt_o} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset: got lmE=%b cnt=%0d expected 000 cnt=0",
               {locked_o, match_o, error_o}, err_cnt_o);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({locked_o, match_o, error_o, err_cnt_o} !== 19'd0) begin
      errors++;
      $display("FAIL held_reset: got lmE=%b cnt=%0d expected 000 cnt=0",
               {locked_o, match_o, error_o}, err_cnt_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 32'd0);
    drive(1'b1, 32'd1);
    checks++;
    if ({locked_o, match_o, error_o} !== 3'b110) begin
      errors++;
      $display("FAIL post_reset_m1: got lmE=%b expected 110", {locked_o, match_o, error_o});
    end
    drive(1'b1, 32'd1);
    checks++;
    if ({locked_o, match_o, error_o} !== 3'b110) begin
      errors++;
      $display("FAIL post_reset_m2: got lmE=%b expected 110", {locked_o, match_o, error_o});
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    do_reset();
    drive2(1'b1, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      drive2(1'b1, 32'd77);
      exp_cnt = (CNT_ON != 0) ? ((k > 3) ? 2'd3 : 2'(k)) : 2'd0;
      checks++;
      if ({locked2, match2, error2, err_cnt2} !== {3'b101, exp_cnt}) begin
        errors++;
        $display("FAIL sat%0d: got lmE=%b cnt=%0d expected 101 cnt=%0d", k,
                 {locked2, match2, error2}, err_cnt2, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_loss_of_lock();
    test_gaps();
    test_reset_mid_track();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
